// File: rtl/ps2_key_event_gen_pkg.sv
// Shared types for the ps2_key event generator: event record, ps2_key bit positions, emitter states.
package ps2_key_pkg;

   typedef struct packed {
      logic       pressed;
      logic       ext;
      logic [7:0] code;
   } key_evt_t;

   localparam int KEY_TOGGLE_BIT  = 10;
   localparam int KEY_PRESSED_BIT = 9;
   localparam int KEY_EXT_BIT     = 8;

   typedef enum logic [1:0] {
      EMIT_IDLE,
      EMIT_OUT,
      EMIT_GAP
   } emit_state_t;

   function automatic key_evt_t mk_evt(input logic pressed, input logic [8:0] ecode);
      key_evt_t e;
      e.pressed = pressed;
      e.ext     = ecode[8];
      e.code    = ecode[7:0];
      return e;
   endfunction

endpackage

// File: rtl/ps2_key_event_gen_fifo.sv
// Single-clock show-ahead FIFO of key events; DEPTH must be a power of two so pointers wrap for free.
module key_evt_fifo
   import ps2_key_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  key_evt_t                 evt_i,
   input  logic                     pop_i,
   output key_evt_t                 evt_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   key_evt_t          mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AW:0]       level_q;
   logic              do_push, do_pop;

   assign full_o  = (level_q == (AW+1)'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign evt_o   = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= evt_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + (AW+1)'(1);
            2'b01:   level_q <= level_q - (AW+1)'(1);
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/ps2_key_event_gen.sv
// Turns key levels into ps2_key toggle-strobe events via a round-robin scanner, event FIFO and paced emitter.
// Optional auto-repeat of the last pressed key is built when PS2_KEY_TYPEMATIC_EN is defined.
module ps2_key_event_gen
   import ps2_key_pkg::*;
#(
   parameter int NUM_KEYS      = 16,
   parameter int FIFO_DEPTH    = 8,
   parameter int GAP_CYCLES    = 64,
   parameter int REPEAT_DELAY  = 20000000,
   parameter int REPEAT_PERIOD = 4000000
) (
   input  logic                            clk_sys,
   input  logic                            reset,
   input  logic [NUM_KEYS-1:0]             key_state,
   input  logic [NUM_KEYS*9-1:0]           key_codes,
   output logic [10:0]                     ps2_key,
   output logic                            busy,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

   localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam int GW = $clog2(GAP_CYCLES);

   if (NUM_KEYS < 1 || NUM_KEYS > 64) begin : g_bad_keys
      $error("NUM_KEYS must be 1..64");
   end
   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 32 || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two in 2..32");
   end
   if (GAP_CYCLES < 2) begin : g_bad_gap
      $error("GAP_CYCLES must be >= 2");
   end
   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rep
      $error("REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
   end

   logic [8:0]          code_tab [NUM_KEYS];
   logic [IW-1:0]       idx_q;
   logic [NUM_KEYS-1:0] reported_q;
   logic                scan_push, push, pop;
   key_evt_t            push_evt, head_evt;
   logic                fifo_full, fifo_empty;
   emit_state_t         state_q;
   logic [GW-1:0]       gap_q;
   logic [10:0]         ps2_q;

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_code
      assign code_tab[g] = key_codes[9*g +: 9];
   end

   // fifo_full is the start-of-cycle occupancy, so a same-cycle pop never makes room
   assign scan_push = (key_state[idx_q] != reported_q[idx_q]) && !fifo_full;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         idx_q      <= '0;
         reported_q <= '0;
      end else begin
         idx_q <= (idx_q == IW'(NUM_KEYS-1)) ? '0 : idx_q + IW'(1);
         if (scan_push) reported_q[idx_q] <= key_state[idx_q];
      end
   end

`ifdef PS2_KEY_TYPEMATIC_EN
   logic          rep_act_q, rep_first_q, rep_pend_q;
   logic [IW-1:0] rep_idx_q;
   logic [31:0]   rep_cnt_q;
   logic          rep_push, rep_hit;

   assign rep_push = rep_pend_q && !scan_push && !fifo_full;
   assign rep_hit  = rep_first_q ? (rep_cnt_q == 32'(REPEAT_DELAY - 1))
                                 : (rep_cnt_q == 32'(REPEAT_PERIOD - 1));
   assign push     = scan_push || rep_push;
   assign push_evt = scan_push ? mk_evt(key_state[idx_q], code_tab[idx_q])
                               : mk_evt(1'b1, code_tab[rep_idx_q]);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         rep_act_q   <= 1'b0;
         rep_first_q <= 1'b0;
         rep_pend_q  <= 1'b0;
         rep_idx_q   <= '0;
         rep_cnt_q   <= '0;
      end else if (scan_push && key_state[idx_q]) begin
         rep_act_q   <= 1'b1;
         rep_first_q <= 1'b1;
         rep_pend_q  <= 1'b0;
         rep_idx_q   <= idx_q;
         rep_cnt_q   <= '0;
      end else if (scan_push && idx_q == rep_idx_q) begin
         rep_act_q  <= 1'b0;
         rep_pend_q <= 1'b0;
      end else if (rep_act_q) begin
         if (rep_push) rep_pend_q <= 1'b0;
         if (rep_hit) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b0;
            rep_pend_q  <= 1'b1;
         end else begin
            rep_cnt_q <= rep_cnt_q + 32'd1;
         end
      end
   end
`else
   assign push     = scan_push;
   assign push_evt = mk_evt(key_state[idx_q], code_tab[idx_q]);
`endif

   key_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_sys),
      .rst_i   (reset),
      .push_i  (push),
      .evt_i   (push_evt),
      .pop_i   (pop),
      .evt_o   (head_evt),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign pop = (state_q == EMIT_OUT);

   // GAP counts GAP_CYCLES-1..0, giving GAP_CYCLES+2 cycles between strobes
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= EMIT_IDLE;
         gap_q   <= '0;
         ps2_q   <= '0;
      end else begin
         case (state_q)
            EMIT_IDLE: if (!fifo_empty) state_q <= EMIT_OUT;
            EMIT_OUT: begin
               ps2_q   <= {~ps2_q[KEY_TOGGLE_BIT], head_evt};
               gap_q   <= GW'(GAP_CYCLES - 1);
               state_q <= EMIT_GAP;
            end
            EMIT_GAP: begin
               if (gap_q == '0) state_q <= EMIT_IDLE;
               else             gap_q   <= gap_q - GW'(1);
            end
            default: state_q <= EMIT_IDLE;
         endcase
      end
   end

   assign ps2_key = ps2_q;
   assign busy    = !fifo_empty || (state_q != EMIT_IDLE);

endmodule

// File: tb/tb_ps2_key_event_gen.sv
// Random and directed checks of ps2_key_event_gen against a set-based event model.
module tb_ps2_key_event_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [15:0]  ks_a, ks_b, ks_c;
   logic [143:0] codes_a, codes_b, codes_c;
   logic [10:0]  ps2_a, ps2_b, ps2_c;
   logic         busy_a, busy_b, busy_c;
   logic [3:0]   lvl_a, lvl_c;
   logic [1:0]   lvl_b;

   ps2_key_event_gen dut_a (
      .clk_sys(clk), .reset(rst), .key_state(ks_a), .key_codes(codes_a),
      .ps2_key(ps2_a), .busy(busy_a), .fifo_level(lvl_a));

   ps2_key_event_gen #(.FIFO_DEPTH(2), .GAP_CYCLES(1000)) dut_b (
      .clk_sys(clk), .reset(rst), .key_state(ks_b), .key_codes(codes_b),
      .ps2_key(ps2_b), .busy(busy_b), .fifo_level(lvl_b));

   ps2_key_event_gen #(.GAP_CYCLES(4), .REPEAT_DELAY(100), .REPEAT_PERIOD(50)) dut_c (
      .clk_sys(clk), .reset(rst), .key_state(ks_c), .key_codes(codes_c),
      .ps2_key(ps2_c), .busy(busy_c), .fifo_level(lvl_c));

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // event monitors: sample 1ns after the active edge
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [9:0] evq_a[$], evq_b[$], evq_c[$];
   logic       prev_a = 1'b0, prev_b = 1'b0, prev_c = 1'b0;
   int         last_a = -1, last_b = -1, min_gap_a = 1000000, min_gap_b = 1000000;
   int         max_lvl_b = 0;

   always @(posedge clk) begin
      #1;
      if (rst) begin
         prev_a = ps2_a[10]; prev_b = ps2_b[10]; prev_c = ps2_c[10];
         last_a = -1; last_b = -1;
      end else begin
         if (ps2_a[10] != prev_a) begin
            prev_a = ps2_a[10];
            evq_a.push_back(ps2_a[9:0]);
            if (last_a >= 0 && cyc - last_a < min_gap_a) min_gap_a = cyc - last_a;
            last_a = cyc;
         end
         if (ps2_b[10] != prev_b) begin
            prev_b = ps2_b[10];
            evq_b.push_back(ps2_b[9:0]);
            if (last_b >= 0 && cyc - last_b < min_gap_b) min_gap_b = cyc - last_b;
            last_b = cyc;
         end
         if (ps2_c[10] != prev_c) begin
            prev_c = ps2_c[10];
            evq_c.push_back(ps2_c[9:0]);
         end
      end
      if (int'(lvl_b) > max_lvl_b) max_lvl_b = int'(lvl_b);
   end

   task automatic drain(input int which, input string tag);
      int t;
      logic b;
      repeat (20) @(negedge clk);
      t = 0;
      b = (which == 0) ? busy_a : (which == 1) ? busy_b : busy_c;
      while (b && t < 20000) begin
         @(negedge clk);
         t++;
         b = (which == 0) ? busy_a : (which == 1) ? busy_b : busy_c;
      end
      if (b) chk({tag, "_timeout"}, 32'd1, 32'd0);
   endtask

   // compare observed events against the expected set: each expected event exactly once
   task automatic match_set(input string tag, input logic [9:0] obs[$], input logic [9:0] exp_in[$]);
      logic [9:0] exp[$];
      int unmatched, hit;
      exp = exp_in;
      unmatched = 0;
      chk({tag, "_cnt"}, obs.size(), exp.size());
      foreach (obs[i]) begin
         hit = -1;
         foreach (exp[j]) if (hit < 0 && exp[j] == obs[i]) hit = j;
         if (hit < 0) unmatched++;
         else exp.delete(hit);
      end
      chk({tag, "_match"}, unmatched, 0);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [9:0] exp[$];
      logic [15:0] mask, nks;
      logic [9:0] e;
      int t, k, nmake, nbreak;

      rst = 1'b1;
      ks_a = '0; ks_b = '0; ks_c = '0;
      for (int i = 0; i < 16; i++) begin
         codes_a[9*i +: 9] = 9'($urandom);
         codes_b[9*i +: 9] = 9'($urandom);
         codes_c[9*i +: 9] = 9'($urandom);
      end
      codes_a[27 +: 9] = 9'h075;
      repeat (3) @(negedge clk);
      chk("rst_ps2", ps2_a, 11'h0);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_lvl", lvl_a, 4'd0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("idle_noevt", evq_a.size(), 0);

      // key 3 make: latency, value, busy through the gap
      evq_a.delete();
      ks_a[3] = 1'b1;
      t = 0;
      while (evq_a.size() == 0 && t < 40) begin @(negedge clk); t++; end
      chk("t1_lat", (t <= 18), 1'b1);
      chk("t1_val", ps2_a[9:0], 10'h275);
      chk("t1_busy", busy_a, 1'b1);
      repeat (63) @(negedge clk);
      chk("t1_busy_gap", busy_a, 1'b1);
      @(negedge clk);
      chk("t1_busy_end", busy_a, 1'b0);

      // key 3 break
      evq_a.delete();
      ks_a[3] = 1'b0;
      drain(0, "t2");
      chk("t2_cnt", evq_a.size(), 1);
      e = (evq_a.size() > 0) ? evq_a[0] : 10'bx;
      chk("t2_val", e, 10'h075);

      // random multi-key changes, including more than FIFO_DEPTH at once
      for (int it = 0; it < 15; it++) begin
         for (int i = 0; i < 16; i++) codes_a[9*i +: 9] = 9'($urandom);
         mask = 16'($urandom);
         if (it % 3 == 0) mask = 16'(1) << $urandom_range(0, 15);
         if (mask == 0) mask = 16'h8001;
         nks = ks_a ^ mask;
         exp.delete();
         for (int i = 0; i < 16; i++) if (mask[i]) exp.push_back({nks[i], codes_a[9*i +: 9]});
         evq_a.delete();
         ks_a = nks;
         drain(0, "rnd");
         match_set("rnd", evq_a, exp);
      end
      chk("min_gap_a", (min_gap_a >= 66), 1'b1);

      // single-cycle pulse: either missed entirely or seen as a make/break pair
      for (int it = 0; it < 3; it++) begin
         k = $urandom_range(0, 15);
         evq_a.delete();
         ks_a[k] = ~ks_a[k];
         @(negedge clk);
         ks_a[k] = ~ks_a[k];
         drain(0, "pulse");
         chk("pulse_n", (evq_a.size() == 0 || evq_a.size() == 2), 1'b1);
         if (evq_a.size() == 2) begin
            chk("pulse_e0", evq_a[0], {~ks_a[k], codes_a[9*k +: 9]});
            chk("pulse_e1", evq_a[1], {ks_a[k], codes_a[9*k +: 9]});
         end
      end

      // key 5 held through reset
      rst = 1'b1;
      ks_a = 16'h0020;
      repeat (3) @(negedge clk);
      chk("t4_rst_ps2", ps2_a, 11'h0);
      evq_a.delete();
      rst = 1'b0;
      drain(0, "t4");
      chk("t4_cnt", evq_a.size(), 1);
      e = (evq_a.size() > 0) ? evq_a[0] : 10'bx;
      chk("t4_val", e, {1'b1, codes_a[45 +: 9]});
      chk("t4_tog", ps2_a[10], 1'b1);

      // reset with three events queued during the gap
      ks_a = 16'h0F00;
      drain(0, "t5a");
      evq_a.delete();
      ks_a = 16'h0000;
      t = 0;
      while (evq_a.size() == 0 && t < 40) begin @(negedge clk); t++; end
      repeat (20) @(negedge clk);
      chk("t5_queued", lvl_a, 4'd3);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_ps2", ps2_a, 11'h0);
      chk("t5_lvl", lvl_a, 4'd0);
      chk("t5_busy", busy_a, 1'b0);
      rst = 1'b0;
      evq_a.delete();
      repeat (300) @(negedge clk);
      chk("t5_quiet", evq_a.size(), 0);

      // small FIFO, long gap: six simultaneous makes
      evq_b.delete();
      max_lvl_b = 0;
      exp.delete();
      for (int i = 0; i < 6; i++) exp.push_back({1'b1, codes_b[9*i +: 9]});
      ks_b = 16'h003F;
      drain(1, "t3");
      match_set("t3", evq_b, exp);
      chk("t3_lvl_max", (max_lvl_b <= 2), 1'b1);
      chk("t3_gap", (min_gap_b >= 1002), 1'b1);

      // hold key 1 for 300 cycles
      evq_c.delete();
      ks_c[1] = 1'b1;
      repeat (300) @(negedge clk);
      ks_c[1] = 1'b0;
      drain(2, "t6");
      nmake = 0; nbreak = 0;
      foreach (evq_c[i]) begin
         if (evq_c[i] == {1'b1, codes_c[9 +: 9]}) nmake++;
         else if (evq_c[i] == {1'b0, codes_c[9 +: 9]}) nbreak++;
      end
      chk("t6_break", nbreak, 1);
      chk("t6_total", evq_c.size(), nmake + nbreak);
`ifdef PS2_KEY_TYPEMATIC_EN
      chk("t6_make", (nmake >= 5 && nmake <= 6), 1'b1);
`else
      chk("t6_make", nmake, 1);
`endif
      e = (evq_c.size() > 0) ? evq_c[evq_c.size()-1] : 10'bx;
      chk("t6_last_break", e, {1'b0, codes_c[9 +: 9]});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
